// File: rtl/clock_pkg.sv
// Shared calendar constants and helpers for the set, time-keeping and alarm stages.
package clock_pkg;

   localparam int unsigned SEC_W   = 6;
   localparam int unsigned MIN_W   = 6;
   localparam int unsigned HOUR_W  = 5;
   localparam int unsigned DAY_W   = 5;
   localparam int unsigned MONTH_W = 4;

   localparam logic [SEC_W-1:0]   MAX_SEC   = 6'd59;
   localparam logic [MIN_W-1:0]   MAX_MIN   = 6'd59;
   localparam logic [HOUR_W-1:0]  MAX_HOUR  = 5'd23;
   localparam logic [MONTH_W-1:0] MAX_MONTH = 4'd12;

   // Days in a month; no leap years. Out-of-range months fall to 31.
   function automatic logic [DAY_W-1:0] month_len(input logic [MONTH_W-1:0] month);
      logic [DAY_W-1:0] len;
      case (month)
         4'd2:                      len = 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   len = 5'd30;
         default:                   len = 5'd31;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 and flags the terminal cycle.
// tick is combinational so the consumer can register its update on the wrap edge.
module tick_gen #(
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned PRESC_W       = $clog2(TICKS_PER_SEC)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [PRESC_W-1:0] TERM = PRESC_W'(TICKS_PER_SEC - 1);

   logic [PRESC_W-1:0] r_cnt;
   logic               w_term;

   assign w_term = (r_cnt == TERM);
   // Advance only when the count is live; a clear on the terminal cycle swallows the tick.
   assign tick   = en & ~clr & w_term;

   // Prescaler register: reset and clear restart the phase, !en freezes it.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_term ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/time_keeper.sv
// Free-running month/day/hour/minute/second counter, loaded from the set stage
// and advanced once per second by the prescaler.
module time_keeper
   import clock_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned PRESC_W       = $clog2(TICKS_PER_SEC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               hold,
   input  logic [SEC_W-1:0]   ld_sec,
   input  logic [MIN_W-1:0]   ld_min,
   input  logic [HOUR_W-1:0]  ld_hour,
   input  logic [DAY_W-1:0]   ld_day,
   input  logic [MONTH_W-1:0] ld_month,
   output logic [SEC_W-1:0]   sec,
   output logic [MIN_W-1:0]   min,
   output logic [HOUR_W-1:0]  hour,
   output logic [DAY_W-1:0]   day,
   output logic [MONTH_W-1:0] month,
   output logic               sec_tick,
   output logic               year_wrap
);

   logic [SEC_W-1:0]   r_sec;
   logic [MIN_W-1:0]   r_min;
   logic [HOUR_W-1:0]  r_hour;
   logic [DAY_W-1:0]   r_day;
   logic [MONTH_W-1:0] r_month;
   logic               r_sec_tick;
   logic               r_year_wrap;

   logic               w_tick;

   // Clamped load values
   logic [SEC_W-1:0]   w_ld_sec;
   logic [MIN_W-1:0]   w_ld_min;
   logic [HOUR_W-1:0]  w_ld_hour;
   logic [DAY_W-1:0]   w_ld_day;
   logic [MONTH_W-1:0] w_ld_month;
   logic [DAY_W-1:0]   w_ld_mlen;

   // Cascade carries and next values
   logic               w_sec_wrap;
   logic               w_min_wrap;
   logic               w_hour_wrap;
   logic               w_day_wrap;
   logic               w_year_wrap;
   logic [SEC_W-1:0]   w_sec_nx;
   logic [MIN_W-1:0]   w_min_nx;
   logic [HOUR_W-1:0]  w_hour_nx;
   logic [DAY_W-1:0]   w_day_nx;
   logic [MONTH_W-1:0] w_month_nx;

   tick_gen #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .PRESC_W       (PRESC_W)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (load),
      .en   (~hold),
      .tick (w_tick)
   );

   // Clamp the set-stage values into a legal date/time; day is bounded by the clamped month.
   always_comb begin
      w_ld_month = ld_month;
      if (ld_month == '0) begin
         w_ld_month = 4'd1;
      end else if (ld_month > MAX_MONTH) begin
         w_ld_month = MAX_MONTH;
      end
      w_ld_mlen = month_len(w_ld_month);
      w_ld_day  = ld_day;
      if (ld_day == '0) begin
         w_ld_day = 5'd1;
      end else if (ld_day > w_ld_mlen) begin
         w_ld_day = w_ld_mlen;
      end
      w_ld_hour = (ld_hour > MAX_HOUR) ? MAX_HOUR : ld_hour;
      w_ld_min  = (ld_min  > MAX_MIN)  ? MAX_MIN  : ld_min;
      w_ld_sec  = (ld_sec  > MAX_SEC)  ? MAX_SEC  : ld_sec;
   end

   // One-second advance with full carry chain resolved in a single cycle.
   always_comb begin
      w_sec_wrap  = (r_sec == MAX_SEC);
      w_min_wrap  = w_sec_wrap  && (r_min == MAX_MIN);
      w_hour_wrap = w_min_wrap  && (r_hour == MAX_HOUR);
      w_day_wrap  = w_hour_wrap && (r_day == month_len(r_month));
      w_year_wrap = w_day_wrap  && (r_month == MAX_MONTH);

      w_sec_nx   = w_sec_wrap ? '0 : r_sec + 1'b1;
      w_min_nx   = r_min;
      w_hour_nx  = r_hour;
      w_day_nx   = r_day;
      w_month_nx = r_month;
      if (w_sec_wrap) begin
         w_min_nx = w_min_wrap ? '0 : r_min + 1'b1;
      end
      if (w_min_wrap) begin
         w_hour_nx = w_hour_wrap ? '0 : r_hour + 1'b1;
      end
      if (w_hour_wrap) begin
         w_day_nx = w_day_wrap ? 5'd1 : r_day + 1'b1;
      end
      if (w_day_wrap) begin
         w_month_nx = w_year_wrap ? 4'd1 : r_month + 1'b1;
      end
   end

   // Time registers: rst > load > hold > count. Hold is implicit since w_tick needs en.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sec       <= '0;
         r_min       <= '0;
         r_hour      <= '0;
         r_day       <= 5'd1;
         r_month     <= 4'd1;
         r_sec_tick  <= 1'b0;
         r_year_wrap <= 1'b0;
      end else if (load) begin
         r_sec       <= w_ld_sec;
         r_min       <= w_ld_min;
         r_hour      <= w_ld_hour;
         r_day       <= w_ld_day;
         r_month     <= w_ld_month;
         r_sec_tick  <= 1'b0;
         r_year_wrap <= 1'b0;
      end else begin
         r_sec_tick  <= w_tick;
         r_year_wrap <= w_tick && w_year_wrap;
         if (w_tick) begin
            r_sec   <= w_sec_nx;
            r_min   <= w_min_nx;
            r_hour  <= w_hour_nx;
            r_day   <= w_day_nx;
            r_month <= w_month_nx;
         end
      end
   end

   assign sec       = r_sec;
   assign min       = r_min;
   assign hour      = r_hour;
   assign day       = r_day;
   assign month     = r_month;
   assign sec_tick  = r_sec_tick;
   assign year_wrap = r_year_wrap;

endmodule

// File: tb/tb_time_keeper.sv
// Directed self-checking bench for time_keeper with a 4-cycle second.
module tb_time_keeper;

   logic       clk;
   logic       rst;
   logic       load;
   logic       hold;
   logic [5:0] ld_sec;
   logic [5:0] ld_min;
   logic [4:0] ld_hour;
   logic [4:0] ld_day;
   logic [3:0] ld_month;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [4:0] day;
   logic [3:0] month;
   logic       sec_tick;
   logic       year_wrap;

   int n_cmp;
   int n_err;

   time_keeper #(
      .TICKS_PER_SEC (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .hold      (hold),
      .ld_sec    (ld_sec),
      .ld_min    (ld_min),
      .ld_hour   (ld_hour),
      .ld_day    (ld_day),
      .ld_month  (ld_month),
      .sec       (sec),
      .min       (min),
      .hour      (hour),
      .day       (day),
      .month     (month),
      .sec_tick  (sec_tick),
      .year_wrap (year_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [3:0] mo, input logic [4:0] d, input logic [4:0] h,
                          input logic [5:0] mi, input logic [5:0] s);
      ld_month = mo;
      ld_day   = d;
      ld_hour  = h;
      ld_min   = mi;
      ld_sec   = s;
      load     = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      int ticks;
      int last;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_cmp++;
      if ({month, day, hour, min, sec, sec_tick, year_wrap} !== {4'd1, 5'd1, 5'd0, 6'd0, 6'd0, 2'b00}) begin
         n_err++;
         $display("FAIL reset_state: got %0d/%0d %0d:%0d:%0d t=%b y=%b want 1/1 0:0:0 t=0 y=0",
                  month, day, hour, min, sec, sec_tick, year_wrap);
      end
      ticks = 0;
      last  = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (sec_tick === 1'b1) begin
            ticks++;
            n_cmp++;
            if (i - last != 4) begin
               n_err++;
               $display("FAIL tick_spacing: tick at cycle %0d, previous %0d, want gap 4", i, last);
            end
            last = i;
         end
      end
      n_cmp++;
      if (ticks != 3) begin
         n_err++;
         $display("FAIL tick_count: got %0d want 3", ticks);
      end
      n_cmp++;
      if ({month, day, hour, min, sec} !== {4'd1, 5'd1, 5'd0, 6'd0, 6'd3}) begin
         n_err++;
         $display("FAIL count_12: got %0d/%0d %0d:%0d:%0d want 1/1 0:0:3",
                  month, day, hour, min, sec);
      end
   endtask

   task automatic test_month_carry();
      int wraps;
      do_load(4'd2, 5'd28, 5'd23, 6'd59, 6'd59);
      n_cmp++;
      if ({month, day, hour, min, sec, sec_tick} !== {4'd2, 5'd28, 5'd23, 6'd59, 6'd59, 1'b0}) begin
         n_err++;
         $display("FAIL feb_load: got %0d/%0d %0d:%0d:%0d t=%b want 2/28 23:59:59 t=0",
                  month, day, hour, min, sec, sec_tick);
      end
      wraps = 0;
      for (int i = 1; i <= 4; i++) begin
         step();
         if (year_wrap === 1'b1) wraps++;
      end
      n_cmp++;
      if ({month, day, hour, min, sec, sec_tick} !== {4'd3, 5'd1, 5'd0, 6'd0, 6'd0, 1'b1}) begin
         n_err++;
         $display("FAIL feb_carry: got %0d/%0d %0d:%0d:%0d t=%b want 3/1 0:0:0 t=1",
                  month, day, hour, min, sec, sec_tick);
      end
      n_cmp++;
      if (wraps != 0) begin
         n_err++;
         $display("FAIL feb_no_year_wrap: got %0d pulses want 0", wraps);
      end
   endtask

   task automatic test_year_wrap();
      logic [4:0] seen;
      do_load(4'd12, 5'd31, 5'd23, 6'd59, 6'd59);
      for (int i = 0; i < 5; i++) begin
         step();
         seen[i] = year_wrap;
         if (i == 3) begin
            n_cmp++;
            if ({month, day, hour, min, sec} !== {4'd1, 5'd1, 5'd0, 6'd0, 6'd0}) begin
               n_err++;
               $display("FAIL year_carry: got %0d/%0d %0d:%0d:%0d want 1/1 0:0:0",
                        month, day, hour, min, sec);
            end
         end
      end
      n_cmp++;
      if (seen !== 5'b01000) begin
         n_err++;
         $display("FAIL year_wrap_pulse: got %b want 01000", seen);
      end
   endtask

   task automatic test_clamp();
      do_load(4'd15, 5'd31, 5'd30, 6'd63, 6'd60);
      n_cmp++;
      if ({month, day, hour, min, sec} !== {4'd12, 5'd31, 5'd23, 6'd59, 6'd59}) begin
         n_err++;
         $display("FAIL clamp_high: got %0d/%0d %0d:%0d:%0d want 12/31 23:59:59",
                  month, day, hour, min, sec);
      end
      do_load(4'd4, 5'd31, 5'd10, 6'd5, 6'd6);
      n_cmp++;
      if ({month, day, hour, min, sec} !== {4'd4, 5'd30, 5'd10, 6'd5, 6'd6}) begin
         n_err++;
         $display("FAIL clamp_apr31: got %0d/%0d %0d:%0d:%0d want 4/30 10:5:6",
                  month, day, hour, min, sec);
      end
      do_load(4'd0, 5'd0, 5'd1, 6'd2, 6'd3);
      n_cmp++;
      if ({month, day, hour, min, sec} !== {4'd1, 5'd1, 5'd1, 6'd2, 6'd3}) begin
         n_err++;
         $display("FAIL clamp_zero: got %0d/%0d %0d:%0d:%0d want 1/1 1:2:3",
                  month, day, hour, min, sec);
      end
      do_load(4'd2, 5'd30, 5'd0, 6'd0, 6'd0);
      n_cmp++;
      if ({month, day} !== {4'd2, 5'd28}) begin
         n_err++;
         $display("FAIL clamp_feb30: got %0d/%0d want 2/28", month, day);
      end
   endtask

   task automatic test_hold();
      int ticks;
      int moved;
      do_load(4'd5, 5'd10, 5'd10, 6'd20, 6'd30);
      step();
      step();
      // prescaler now at 2
      hold  = 1'b1;
      ticks = 0;
      moved = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (sec_tick === 1'b1) ticks++;
         if ({month, day, hour, min, sec} !== {4'd5, 5'd10, 5'd10, 6'd20, 6'd30}) moved++;
      end
      n_cmp++;
      if (ticks != 0 || moved != 0) begin
         n_err++;
         $display("FAIL hold_freeze: got %0d ticks %0d changed cycles want 0 0", ticks, moved);
      end
      hold = 1'b0;
      step();
      n_cmp++;
      if (sec_tick !== 1'b0) begin
         n_err++;
         $display("FAIL hold_resume_early: got t=%b want 0 one cycle after release", sec_tick);
      end
      step();
      n_cmp++;
      if ({sec_tick, sec} !== {1'b1, 6'd31}) begin
         n_err++;
         $display("FAIL hold_resume_phase: got t=%b sec=%0d want t=1 sec=31", sec_tick, sec);
      end
   endtask

   task automatic test_load_in_hold();
      hold = 1'b1;
      do_load(4'd7, 5'd31, 5'd23, 6'd59, 6'd59);
      n_cmp++;
      if ({month, day, hour, min, sec} !== {4'd7, 5'd31, 5'd23, 6'd59, 6'd59}) begin
         n_err++;
         $display("FAIL load_in_hold: got %0d/%0d %0d:%0d:%0d want 7/31 23:59:59",
                  month, day, hour, min, sec);
      end
      step();
      step();
      hold = 1'b0;
      for (int i = 0; i < 4; i++) step();
      n_cmp++;
      if ({month, day, hour, min, sec, sec_tick} !== {4'd8, 5'd1, 5'd0, 6'd0, 6'd0, 1'b1}) begin
         n_err++;
         $display("FAIL jul_carry: got %0d/%0d %0d:%0d:%0d t=%b want 8/1 0:0:0 t=1",
                  month, day, hour, min, sec, sec_tick);
      end
   endtask

   task automatic test_load_at_terminal();
      logic [3:0] seen;
      do_load(4'd6, 5'd15, 5'd8, 6'd0, 6'd0);
      step();
      step();
      step();
      // prescaler at terminal on the next edge; load must win
      do_load(4'd9, 5'd9, 5'd9, 6'd9, 6'd9);
      n_cmp++;
      if ({month, day, hour, min, sec, sec_tick} !== {4'd9, 5'd9, 5'd9, 6'd9, 6'd9, 1'b0}) begin
         n_err++;
         $display("FAIL load_at_term: got %0d/%0d %0d:%0d:%0d t=%b want 9/9 9:9:9 t=0",
                  month, day, hour, min, sec, sec_tick);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         seen[i] = sec_tick;
      end
      n_cmp++;
      if ({seen, sec} !== {4'b1000, 6'd10}) begin
         n_err++;
         $display("FAIL load_at_term_cadence: got ticks %b sec=%0d want 1000 sec=10", seen, sec);
      end
   endtask

   task automatic test_reset_midcount();
      logic [3:0] seen;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({month, day, hour, min, sec, sec_tick} !== {4'd1, 5'd1, 5'd0, 6'd0, 6'd0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_mid: got %0d/%0d %0d:%0d:%0d t=%b want 1/1 0:0:0 t=0",
                  month, day, hour, min, sec, sec_tick);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         seen[i] = sec_tick;
      end
      n_cmp++;
      if (seen !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_mid_cadence: got %b want 1000", seen);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b0;
      load     = 1'b0;
      hold     = 1'b0;
      ld_sec   = '0;
      ld_min   = '0;
      ld_hour  = '0;
      ld_day   = '0;
      ld_month = '0;
      test_reset();
      test_month_carry();
      test_year_wrap();
      test_clamp();
      test_hold();
      test_load_in_hold();
      test_load_at_terminal();
      test_reset_midcount();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
